// File: rtl/hazard_sb_if.sv
// Hazard scoreboard signal bundle: pipeline-stage register tags and
// control flags in, stall/flush/forward controls and MD status out.
// Ports:
//   master : drives the stage tags/flags, receives controls (pipeline side)
//   slave  : receives the stage tags/flags, drives controls (hazard_sb side)
interface hazard_sb_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic [AW-1:0]    rsD;
    logic [AW-1:0]    rtD;
    logic [AW-1:0]    rsE;
    logic [AW-1:0]    rtE;
    logic [AW-1:0]    waddrE;
    logic [AW-1:0]    waddrM;
    logic [AW-1:0]    waddrW;
    logic             regwriteE;
    logic             regwriteM;
    logic             regwriteW;
    logic             memtoRegE;
    logic             memtoRegM;
    logic             branchD;
    logic             mdD;
    logic             hiloRdD;
    logic             excM;
    logic             clr_cnt;

    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             forwardAD;
    logic             forwardBD;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rsD, rtD, rsE, rtE, waddrE, waddrM, waddrW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
               branchD, mdD, hiloRdD, excM, clr_cnt,
        input  stallF, stallD, flushD, flushE, flushM,
               forwardAD, forwardBD, forwardAE, forwardBE,
               md_busy, md_done, stall_cnt
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, waddrE, waddrM, waddrW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
               branchD, mdD, hiloRdD, excM, clr_cnt,
        output stallF, stallD, flushD, flushE, flushM,
               forwardAD, forwardBD, forwardAE, forwardBE,
               md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/hazard_sb.sv
// Pipeline hazard scoreboard: operand forwarding selects for D and E,
// load-use / branch / mul-div stall detection, exception flushes, a
// multi-cycle MD-unit occupancy counter and a saturating stall counter.
// Ports:
//   clk    : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   hz     : hazard_sb_if.slave bundle (stage tags in, controls out)
// Forwarding and stall/flush outputs are combinational; md_busy/md_done
// decode the registered MD counter; stall_cnt is registered.
module hazard_sb #(
    parameter int unsigned AW     = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    hazard_sb_if.slave hz
);
    localparam int unsigned MD_CNT_W = 4;

    logic [MD_CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall_any;
    logic md_busy_c;
    logic md_done_c;
    logic stall_d_c;

    // Register 0 is hardwired zero, so it never matches a producer.
    function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Forwarding selects: M has priority over W in E.
    always_comb begin
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        if (match(hz.rsE, hz.waddrM) && hz.regwriteM)
            hz.forwardAE = 2'b10;
        else if (match(hz.rsE, hz.waddrW) && hz.regwriteW)
            hz.forwardAE = 2'b01;
        if (match(hz.rtE, hz.waddrM) && hz.regwriteM)
            hz.forwardBE = 2'b10;
        else if (match(hz.rtE, hz.waddrW) && hz.regwriteW)
            hz.forwardBE = 2'b01;
        hz.forwardAD = match(hz.rsD, hz.waddrM) && hz.regwriteM;
        hz.forwardBD = match(hz.rtD, hz.waddrM) && hz.regwriteM;
    end

    assign md_busy_c = (md_cnt != '0);
    assign md_done_c = (md_cnt == MD_CNT_W'(1));

    // Stall sources; an op waiting on the MD unit may go in the done cycle.
    always_comb begin
        lwstall = hz.memtoRegE && hz.regwriteE &&
                  (match(hz.rsD, hz.waddrE) || match(hz.rtD, hz.waddrE));
        brstall = hz.branchD &&
                  ((hz.regwriteE && (match(hz.rsD, hz.waddrE) || match(hz.rtD, hz.waddrE))) ||
                   (hz.memtoRegM && (match(hz.rsD, hz.waddrM) || match(hz.rtD, hz.waddrM))));
        mdstall = md_busy_c && !md_done_c && (hz.mdD || hz.hiloRdD);
        stall_any = lwstall || brstall || mdstall;
    end

    // An exception in M overrides every stall and flushes D/E/M.
    always_comb begin
        stall_d_c = stall_any && !hz.excM;
        hz.stallF = stall_d_c;
        hz.stallD = stall_d_c;
        hz.flushD = hz.excM;
        hz.flushE = hz.excM || stall_any;
        hz.flushM = hz.excM;
    end

    // MD occupancy: load on issue from D, count down to zero, kill on exception.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            md_cnt <= '0;
        else if (hz.excM)
            md_cnt <= '0;
        else if (hz.mdD && !stall_d_c)
            md_cnt <= MD_CNT_W'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - MD_CNT_W'(1);
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else if (hz.clr_cnt)
            stall_cnt_q <= '0;
        else if (stall_d_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign hz.md_busy   = md_busy_c;
    assign hz.md_done   = md_done_c;
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 Parameter AW, default 5: register-address width; register 0 is hardwired zero and never forwarded or stalled on.
REQ-002 Parameter MD_LAT, default 4 (legal 1..15): cycles a multi-cycle mul/div op occupies the MD unit after leaving D.
REQ-003 Parameter CNT_W, default 16: stall performance-counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 rsD, rtD, rsE, rtE  in  AW each  source registers in D and E.
REQ-007 waddrE, waddrM, waddrW  in  AW each  destination registers in E, M, W.
REQ-008 regwriteE, regwriteM, regwriteW  in  1 each  register-write enables.
REQ-009 memtoRegE, memtoRegM  in  1 each  load in E or M.
REQ-010 branchD  in  1  branch resolved in D.
REQ-011 mdD  in  1  D holds a multi-cycle mul/div op; hiloRdD  in  1  D reads HI/LO.
REQ-012 excM  in  1  exception/redirect taken in M.
REQ-013 clr_cnt  in  1  synchronous clear of stall counter.
REQ-014 stallF, stallD, flushD, flushE, flushM  out  1 each  pipeline controls.
REQ-015 forwardAD, forwardBD  out  1 each  D-stage forward from M.
REQ-016 forwardAE, forwardBE  out  2 each  E-stage select: 10 = M, 01 = W, 00 = register file.
REQ-017 md_busy, md_done  out  1 each  MD-unit status; stall_cnt  out  CNT_W  stall-cycle count.

Function
REQ-018 "Match(x,y)" SHALL mean x != 0 and x == y.
REQ-019 forwardAE SHALL be 10 if Match(rsE,waddrM)&regwriteM, else 01 if Match(rsE,waddrW)&regwriteW, else 00; forwardBE is identical using rtE (M priority over W).
REQ-020 forwardAD SHALL be Match(rsD,waddrM)&regwriteM; forwardBD uses rtD.
REQ-021 lwstall SHALL be memtoRegE & regwriteE & (Match(rsD,waddrE) | Match(rtD,waddrE)).
REQ-022 brstall SHALL be branchD & ((regwriteE & (Match(rsD,waddrE)|Match(rtD,waddrE))) | (memtoRegM & (Match(rsD,waddrM)|Match(rtD,waddrM)))).
REQ-023 md_cnt (4-bit register) SHALL load MD_LAT when mdD & ~stallD & ~excM, else decrement when nonzero, else hold 0.
REQ-024 md_busy SHALL be md_cnt != 0; md_done SHALL be md_cnt == 1 (single-cycle pulse per op).
REQ-025 mdstall SHALL be md_busy & ~md_done & (mdD | hiloRdD); in the md_done cycle a dependent op proceeds.
REQ-026 With excM=0: stallF = stallD = flushE = lwstall|brstall|mdstall; flushD = flushM = 0.
REQ-027 excM=1 SHALL override: stallF=stallD=0, flushD=flushE=flushM=1, md_cnt cleared to 0 next edge, no MD load that cycle.
REQ-028 stall_cnt SHALL increment by 1 each cycle stallD=1, saturating at all-ones; clr_cnt=1 clears to 0 next edge and takes priority over increment.
REQ-029 All forwarding outputs are combinational and independent of stall/flush state.

Reset
REQ-030 resetn=0 SHALL asynchronously clear md_cnt and stall_cnt to 0; while in reset md_busy=md_done=0, and stall/flush outputs reflect only combinational inputs (excM forces flushes).
REQ-031 Release of resetn SHALL need no extra cycles; first post-reset edge operates normally.

Verification
REQ-032 Load-use: memtoRegE=1, regwriteE=1, waddrE=5, rsD=5 -> stallF=stallD=flushE=1, stall_cnt +1; waddrE=0, rsD=0 -> no stall.
REQ-033 Forward priority: rsE=7, waddrM=waddrW=7, both regwrite -> forwardAE=10; regwriteM=0 -> 01.
REQ-034 Branch: branchD=1, rtD=3, memtoRegM=1, waddrM=3 -> stall; same with memtoRegM=0, regwriteM=1 -> no stall, forwardBD=1.
REQ-035 MD: mdD=1 one cycle (MD_LAT=4) -> md_busy 4 cycles, md_done in the 4th only; hiloRdD=1 during busy stalls exactly 3 cycles.
REQ-036 Exception: excM=1 with md_cnt=3 and lwstall active -> stalls 0, flushD/E/M=1, md_cnt=0 next cycle.
REQ-037 Counter/reset: CNT_W=2, stall 5 cycles -> stall_cnt=3 (saturated); clr_cnt -> 0; resetn low mid-MD op -> md_busy=0 immediately.
